// File: rtl/onets_rst_seq_if.sv
// Board reset sequencer bus: button and software requests in,
// PHY and core resets plus status out.
interface onets_rst_seq_if #(
  parameter int NUM_PHY = 4
);
  logic               btn_rst_n;
  logic               sw_rst_req;
  logic [NUM_PHY-1:0] phy_rst_n;
  logic               ext_rst;
  logic               core_ready;
  logic [1:0]         rst_cause;
  logic [7:0]         rst_count;

  modport master (
    output btn_rst_n,
    output sw_rst_req,
    input  phy_rst_n,
    input  ext_rst,
    input  core_ready,
    input  rst_cause,
    input  rst_count
  );

  modport slave (
    input  btn_rst_n,
    input  sw_rst_req,
    output phy_rst_n,
    output ext_rst,
    output core_ready,
    output rst_cause,
    output rst_count
  );
endinterface

// File: rtl/onets_rst_seq.sv
// OneTSwitch board reset sequencer: debounced button, PHY reset
// pulse, PHY settle delay and core reset release with status.
module onets_rst_seq #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1250000,
  parameter int PHY_RST_CYCLES    = 1250000,
  parameter int PHY_SETTLE_CYCLES = 6250000,
  parameter int CNT_W             = 24,
  parameter int NUM_PHY           = 4
) (
  input logic           clk,
  input logic           reset,
  onets_rst_seq_if.slave bus
);

  typedef enum logic [1:0] {
    HOLD,
    SETTLE,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(PHY_SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   btn_sync;
  logic                   deb_lvl;
  logic                   deb_prev;
  logic [CNT_W-1:0]       deb_cnt;
  logic                   btn_press;
  logic                   btn_fall;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             req;

  logic [NUM_PHY-1:0] phy_q;
  logic               ext_q;
  logic               rdy_q;
  logic [1:0]         cause_q;
  logic [7:0]         count_q;

  assign btn_sync  = sync[SYNC_STAGES-1];
  assign btn_press = ~deb_lvl;
  assign btn_fall  = deb_prev & ~deb_lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.btn_rst_n};
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_lvl  <= 1'b1;
      deb_prev <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      deb_prev <= deb_lvl;
      if (btn_sync != deb_lvl) begin
        if (deb_cnt == DEB_LAST) begin
          deb_lvl <= btn_sync;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HOLD;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    req      = 1'b0;
    unique case (state)
      HOLD: begin
        if (bus.sw_rst_req || btn_press) begin
          cnt_nx = '0;
        end else if (cnt == RST_LAST) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (btn_fall || bus.sw_rst_req) begin
          state_nx = HOLD;
          cnt_nx   = '0;
          req      = 1'b1;
        end else if (cnt == SET_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_nx = '0;
        if (btn_fall || bus.sw_rst_req) begin
          state_nx = HOLD;
          req      = 1'b1;
        end
      end
      default: begin
        state_nx = HOLD;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they change on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phy_q   <= '0;
      ext_q   <= 1'b1;
      rdy_q   <= 1'b0;
      cause_q <= 2'b00;
      count_q <= 8'd0;
    end else begin
      phy_q <= {NUM_PHY{state_nx != HOLD}};
      ext_q <= (state_nx != RUN);
      rdy_q <= (state_nx == RUN);
      if (req) begin
        cause_q <= btn_fall ? 2'b01 : 2'b10;
        if (count_q != 8'hFF) begin
          count_q <= count_q + 8'd1;
        end
      end
    end
  end

  assign bus.phy_rst_n  = phy_q;
  assign bus.ext_rst    = ext_q;
  assign bus.core_ready = rdy_q;
  assign bus.rst_cause  = cause_q;
  assign bus.rst_count  = count_q;

endmodule

// File: tb/tb_onets_rst_seq.sv
// Directed bench for onets_rst_seq with shortened timing
// (debounce 4, PHY reset 10, settle 20).
module tb_onets_rst_seq;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  onets_rst_seq_if #(.NUM_PHY(4)) bus ();

  onets_rst_seq #(
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (4),
    .PHY_RST_CYCLES   (10),
    .PHY_SETTLE_CYCLES(20),
    .CNT_W            (24),
    .NUM_PHY          (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sw_pulse();
    bus.sw_rst_req = 1'b1;
    tick(1);
    bus.sw_rst_req = 1'b0;
  endtask

  // Called mid-cycle just after reset release
  task automatic power_on(input string tag);
    tick(9);
    chk({tag, "_phy_e9"}, 32'(bus.phy_rst_n), 32'h0);
    tick(1);
    chk({tag, "_phy_e10"}, 32'(bus.phy_rst_n), 32'hF);
    chk({tag, "_ext_e10"}, 32'(bus.ext_rst), 32'h1);
    tick(19);
    chk({tag, "_ext_e29"}, 32'(bus.ext_rst), 32'h1);
    tick(1);
    chk({tag, "_ext_e30"}, 32'(bus.ext_rst), 32'h0);
    chk({tag, "_rdy_e30"}, 32'(bus.core_ready), 32'h1);
    chk({tag, "_cause"}, 32'(bus.rst_cause), 32'h0);
    chk({tag, "_count"}, 32'(bus.rst_count), 32'h0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.btn_rst_n  = 1'b1;
    bus.sw_rst_req = 1'b0;
    tick(2);
    chk("rst_phy", 32'(bus.phy_rst_n), 32'h0);
    chk("rst_ext", 32'(bus.ext_rst), 32'h1);
    chk("rst_rdy", 32'(bus.core_ready), 32'h0);
    chk("rst_cause", 32'(bus.rst_cause), 32'h0);
    chk("rst_count", 32'(bus.rst_count), 32'h0);
    reset = 1'b0;

    // 1: power-on sequence
    power_on("por");

    // 2: 3-cycle glitch is ignored
    bus.btn_rst_n = 1'b0;
    tick(3);
    bus.btn_rst_n = 1'b1;
    tick(10);
    chk("glitch_rdy", 32'(bus.core_ready), 32'h1);
    chk("glitch_phy", 32'(bus.phy_rst_n), 32'hF);
    chk("glitch_count", 32'(bus.rst_count), 32'h0);

    // 3: button held 25 cycles
    bus.btn_rst_n = 1'b0;
    tick(6);
    chk("btn_phy_e6", 32'(bus.phy_rst_n), 32'hF);
    tick(1);
    chk("btn_phy_e7", 32'(bus.phy_rst_n), 32'h0);
    chk("btn_ext_e7", 32'(bus.ext_rst), 32'h1);
    chk("btn_rdy_e7", 32'(bus.core_ready), 32'h0);
    chk("btn_cause", 32'(bus.rst_cause), 32'h1);
    chk("btn_count", 32'(bus.rst_count), 32'h1);
    tick(18);
    chk("btn_held", 32'(bus.phy_rst_n), 32'h0);
    bus.btn_rst_n = 1'b1;
    tick(15);
    chk("rel_phy_e15", 32'(bus.phy_rst_n), 32'h0);
    tick(1);
    chk("rel_phy_e16", 32'(bus.phy_rst_n), 32'hF);
    tick(19);
    chk("rel_ext_e35", 32'(bus.ext_rst), 32'h1);
    tick(1);
    chk("rel_ext_e36", 32'(bus.ext_rst), 32'h0);
    chk("rel_rdy_e36", 32'(bus.core_ready), 32'h1);

    // 4: software reset, then a restart while in HOLD
    sw_pulse();
    chk("sw_phy", 32'(bus.phy_rst_n), 32'h0);
    chk("sw_ext", 32'(bus.ext_rst), 32'h1);
    chk("sw_rdy", 32'(bus.core_ready), 32'h0);
    chk("sw_cause", 32'(bus.rst_cause), 32'h2);
    chk("sw_count", 32'(bus.rst_count), 32'h2);
    tick(5);
    sw_pulse();
    chk("hold_sw_cause", 32'(bus.rst_cause), 32'h2);
    chk("hold_sw_count", 32'(bus.rst_count), 32'h2);
    chk("hold_sw_phy", 32'(bus.phy_rst_n), 32'h0);
    tick(9);
    chk("hold_restart_phy", 32'(bus.phy_rst_n), 32'h0);
    tick(1);
    chk("hold_restart_phy2", 32'(bus.phy_rst_n), 32'hF);
    tick(19);
    chk("sw_rdy_e35", 32'(bus.core_ready), 32'h0);
    tick(1);
    chk("sw_rdy_e36", 32'(bus.core_ready), 32'h1);

    // 5a: btn_fall and sw_rst_req on the same edge
    bus.btn_rst_n = 1'b0;
    tick(6);
    chk("both_rdy_pre", 32'(bus.core_ready), 32'h1);
    sw_pulse();
    chk("both_cause", 32'(bus.rst_cause), 32'h1);
    chk("both_count", 32'(bus.rst_count), 32'h3);
    bus.btn_rst_n = 1'b1;
    tick(35);
    chk("both_rdy_e35", 32'(bus.core_ready), 32'h0);
    tick(1);
    chk("both_rdy_e36", 32'(bus.core_ready), 32'h1);

    // 5b: saturation, requests issued from SETTLE
    for (int i = 0; i < 260; i++) begin
      sw_pulse();
      if (i == 250) begin
        chk("sat_254", 32'(bus.rst_count), 32'd254);
      end
      tick(11);
    end
    chk("sat_count", 32'(bus.rst_count), 32'd255);
    chk("sat_cause", 32'(bus.rst_cause), 32'h2);
    chk("sat_settle_phy", 32'(bus.phy_rst_n), 32'hF);
    chk("sat_settle_ext", 32'(bus.ext_rst), 32'h1);

    // 6: async reset mid-SETTLE, between edges
    #2;
    reset = 1'b1;
    #1;
    chk("arst_phy", 32'(bus.phy_rst_n), 32'h0);
    chk("arst_ext", 32'(bus.ext_rst), 32'h1);
    chk("arst_rdy", 32'(bus.core_ready), 32'h0);
    chk("arst_count", 32'(bus.rst_count), 32'h0);
    chk("arst_cause", 32'(bus.rst_cause), 32'h0);
    tick(2);
    reset = 1'b0;
    power_on("rerun");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
